miner_job_ctrl: RTL and testbench
=================================

Name: miner_job_ctrl

Overview:
- Sequences the iterative sha256_transform pair (uut/uut2) for one mining job at a time.
- Latches a 512-bit job word (midstate + data2 tail) delivered by the MIPI RX path and drives state, input, cnt and feedback to the hashers.
- Sweeps the 32-bit nonce, detects golden tickets on hash2 and presents the corrected nonce on a valid/ready result port toward the MIPI TX path.
- Lives in top, clocked by hash_clk.

Parameters:
- LOOP_LOG2, 5, unroll factor of the hashers; legal range 2..5; LOOP = 1<<LOOP_LOG2.
- NONCE_START, 32'h00000000, first nonce of every job.

Ports:
- hash_clk  in  1  sole clock
- rst_n  in  1  synchronous active-low reset
- job_data  in  512  [511:256] midstate, [255:0] data2; only data2[95:0] is used
- job_valid  in  1  one-cycle strobe, synchronous to hash_clk; starts or restarts a job
- hs_state  out  256  rx_state to first hasher
- hs_input  out  512  rx_input to first hasher
- hs_cnt  out  6  round counter to both hashers
- hs_feedback  out  1  feedback to both hashers
- hs_hash2  in  256  tx_hash of second hasher
- result_nonce  out  32  golden nonce
- result_valid  out  1  result pending
- result_ready  in  1  consumer accepts result
- result_drop  out  1  one-cycle pulse: golden ticket lost because a result was still pending
- busy  out  1  high in HASH or DRAIN
- exhausted  out  1  sticky; nonce space finished without a new job
- cur_nonce  out  32  nonce currently loaded

Behaviour:
- Constants:
  - OFFSET = (1<<(7-LOOP_LOG2))+1
  - FLUSH = OFFSET*LOOP cycles, the pipeline depth from a nonce load to its hash2
- Reset (rst_n=0 at a hash_clk edge):
  - State IDLE.
  - All outputs 0, except hs_feedback=1, hs_cnt=0 and cur_nonce=NONCE_START.
  - Job registers and flush counter cleared; a pending result is discarded.
- hs_input is registered and equals {32'h00000280, 320'h0, 32'h80000000, nonce_next, data2[95:0]}. hs_state is the latched midstate.
- Counter and nonce:
  - cnt_next = (hs_cnt+1) & (LOOP-1).
  - feedback_next = (cnt_next != 0).
  - nonce increments by 1 only on cycles where feedback_next=0.
- States:
  - IDLE: hs_cnt held 0; hs_feedback=1. job_valid -> latch job, nonce=NONCE_START, flush counter=FLUSH, clear exhausted, go HASH next cycle.
  - HASH: cnt/feedback/nonce advance every cycle. When nonce would advance from 32'hFFFFFFFF: no wrap; nonce holds and the hashers are fed the last word; flush counter=FLUSH; go DRAIN.
  - DRAIN: cnt keeps cycling and golden detection stays active. Flush counter expires -> IDLE, exhausted=1.
- job_valid in HASH or DRAIN:
  - Abort and reload exactly as from IDLE; hs_cnt restarts at 0.
  - The golden pipeline is cleared (see golden detection).
  - A pending result is kept.
- Golden detection:
  - gold = (hs_hash2[255:224]==0) && !feedback_d1 && (flush counter==0 in HASH); registered one cycle.
  - In DRAIN, gold is evaluated while the counter is nonzero.
  - feedback_d1 is hs_feedback delayed one cycle.
  - After a (re)start, detection is suppressed until FLUSH cycles have elapsed, so stale work never reports.
- Result:
  - On a registered gold: result_nonce = cur_nonce - OFFSET (mod 2^32).
  - If result_valid=0, set result_valid=1. If result_valid=1 and result_ready=0, pulse result_drop and keep the old value.
  - Simultaneous accept and new gold: the new nonce loads and result_valid stays 1.
  - Handshake: result_valid and result_nonce hold stable until a cycle with result_valid && result_ready, then clear the next edge.
- busy = (state != IDLE).

Test Plan:
- Reset mid-HASH with result_valid=1 -> next cycle result_valid=0, busy=0, hs_cnt=0, hs_feedback=1, cur_nonce=0.
- LOOP_LOG2=5, job_valid with data2[95:0]=96'hA5..: hs_cnt counts 0..31; cur_nonce increments once per 32 cycles; hs_input[95:0]=data2 tail, [127:96]=nonce, [511:480]=32'h00000280.
- Model hs_hash2 top word=0 on the feedback_d1=0 cycle for nonce 100 fed after flush -> result_valid=1 with result_nonce = cur_nonce-5 at detection (value 100).
- Two golden tickets with result_ready=0 -> first value held, result_drop pulses once; result_ready=1 for one cycle -> result_valid low next cycle.
- NONCE_START=32'hFFFFFFF0 -> after 16 nonce advances DRAIN is entered; busy low FLUSH cycles later; exhausted=1; next job_valid clears exhausted.
- job_valid mid-HASH while hs_hash2 reports golden within FLUSH cycles of the restart -> no result; cur_nonce returns to NONCE_START; hs_cnt=0.

Source files
------------

// File: rtl/miner_job_ctrl_if.sv
// miner_job_ctrl_if: job input, hasher drive and golden-nonce result signals of the miner job controller
interface miner_job_ctrl_if;
  logic [511:0] job_data;
  logic job_valid;
  logic [255:0] hs_state;
  logic [511:0] hs_input;
  logic [5:0] hs_cnt;
  logic hs_feedback;
  logic [255:0] hs_hash2;
  logic [31:0] result_nonce;
  logic result_valid;
  logic result_ready;
  logic result_drop;
  logic busy;
  logic exhausted;
  logic [31:0] cur_nonce;
  modport master (
    input job_data, job_valid, hs_hash2, result_ready,
    output hs_state, hs_input, hs_cnt, hs_feedback, result_nonce, result_valid, result_drop, busy, exhausted, cur_nonce
  );
  modport slave (
    output job_data, job_valid, hs_hash2, result_ready,
    input hs_state, hs_input, hs_cnt, hs_feedback, result_nonce, result_valid, result_drop, busy, exhausted, cur_nonce
  );
endinterface

// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: sequences the sha256 hasher pair through a nonce sweep and reports golden nonces
module miner_job_ctrl #(
  parameter int LOOP_LOG2 = 5,
  parameter logic [31:0] NONCE_START = 32'h0000_0000
) (
  input logic hash_clk,
  input logic rst_n,
  miner_job_ctrl_if.master bus
);
  localparam int LOOP = 1 << LOOP_LOG2;
  localparam int OFFSET = (1 << (7 - LOOP_LOG2)) + 1;
  localparam logic [7:0] FLUSH = 8'(OFFSET * LOOP);
  typedef enum logic [1:0] {IDLE, HASH, DRAIN} state_t;
  state_t state, state_n;
  logic [95:0] tail, tail_n;
  logic [31:0] nonce_n;
  logic [7:0] flush, flush_n;
  logic [5:0] cnt_n;
  logic fb_n, fb_d1, exh_n, gold, gold_d, load, unused_bits;
  assign unused_bits = ^{bus.job_data[255:96], bus.hs_hash2[223:0]};
  assign bus.busy = state != IDLE;
  // a restart discards the registered golden ticket along with the rest of the pipeline
  assign load = gold_d && !bus.job_valid;
  always_comb begin
    state_n = state;
    tail_n = tail;
    nonce_n = bus.cur_nonce;
    flush_n = flush - 8'(flush != 8'd0);
    exh_n = bus.exhausted;
    cnt_n = (bus.hs_cnt + 6'd1) & 6'(LOOP - 1);
    gold = bus.hs_hash2[255:224] == 32'd0 && !fb_d1 && (state == DRAIN ? flush != 8'd0 : state == HASH && flush == 8'd0);
    if (bus.job_valid) begin
      state_n = HASH;
      tail_n = bus.job_data[95:0];
      nonce_n = NONCE_START;
      flush_n = FLUSH;
      exh_n = 1'b0;
      cnt_n = 6'd0;
    end else if (state == HASH && cnt_n == 6'd0) begin
      state_n = &bus.cur_nonce ? DRAIN : HASH;
      flush_n = &bus.cur_nonce ? FLUSH : flush_n;
      nonce_n = &bus.cur_nonce ? bus.cur_nonce : bus.cur_nonce + 32'd1;
    end else if (state == DRAIN && flush == 8'd1) begin
      state_n = IDLE;
      exh_n = 1'b1;
    end
    cnt_n = state_n == IDLE ? 6'd0 : cnt_n;
    fb_n = state_n == IDLE || cnt_n != 6'd0;
  end
  always_ff @(posedge hash_clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tail <= '0;
      flush <= '0;
      fb_d1 <= 1'b1;
      gold_d <= 1'b0;
      bus.hs_state <= '0;
      bus.hs_input <= '0;
      bus.hs_cnt <= '0;
      bus.hs_feedback <= 1'b1;
      bus.cur_nonce <= NONCE_START;
      bus.exhausted <= 1'b0;
      bus.result_nonce <= '0;
      bus.result_valid <= 1'b0;
      bus.result_drop <= 1'b0;
    end else begin
      state <= state_n;
      tail <= tail_n;
      flush <= flush_n;
      fb_d1 <= bus.hs_feedback;
      gold_d <= gold && !bus.job_valid;
      if (bus.job_valid) bus.hs_state <= bus.job_data[511:256];
      bus.hs_input <= {32'h0000_0280, 320'h0, 32'h8000_0000, nonce_n, tail_n};
      bus.hs_cnt <= cnt_n;
      bus.hs_feedback <= fb_n;
      bus.cur_nonce <= nonce_n;
      bus.exhausted <= exh_n;
      bus.result_drop <= load && bus.result_valid && !bus.result_ready;
      if (load && (!bus.result_valid || bus.result_ready)) begin
        bus.result_nonce <= bus.cur_nonce - 32'(OFFSET);
        bus.result_valid <= 1'b1;
      end else if (bus.result_valid && bus.result_ready) begin
        bus.result_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_miner_job_ctrl.sv
// tb_miner_job_ctrl: randomized and directed checks of miner_job_ctrl against a cycle-count reference model
module tb_miner_job_ctrl;
  localparam logic [31:0] OFF_A = 32'd5;
  localparam longint FLUSH_A = 160;
  logic hash_clk = 1'b0;
  logic rst_n = 1'b0;
  logic jv_b = 1'b0;
  int checks = 0;
  int errors = 0;
  miner_job_ctrl_if ia();
  miner_job_ctrl_if ib();
  miner_job_ctrl #(.LOOP_LOG2(5), .NONCE_START(32'h0000_0000)) dut_a (.hash_clk(hash_clk), .rst_n(rst_n), .bus(ia.master));
  miner_job_ctrl #(.LOOP_LOG2(2), .NONCE_START(32'hFFFF_FFF0)) dut_b (.hash_clk(hash_clk), .rst_n(rst_n), .bus(ib.master));
  always #5 hash_clk = ~hash_clk;
  // model of instance A: t counts cycles since the last job load
  bit m_busy, m_rv, m_drop, m_gp;
  longint t;
  logic [31:0] m_rn;
  logic [95:0] m_tail;
  logic [255:0] m_mid;
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] m_nonce();
    return m_busy ? 32'(t / 32) : 32'd0;
  endfunction
  function automatic logic [511:0] rand_jd();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction
  task automatic check_a();
    chk("busy", ia.busy, m_busy);
    chk("cnt", ia.hs_cnt, m_busy ? 6'(t % 32) : 6'd0);
    chk("feedback", ia.hs_feedback, !m_busy || (t % 32 != 0));
    chk("nonce", ia.cur_nonce, m_nonce());
    chk("result_valid", ia.result_valid, m_rv);
    chk("result_nonce", ia.result_nonce, m_rn);
    chk("result_drop", ia.result_drop, m_drop);
    chk("exhausted", ia.exhausted, 1'b0);
    if (m_busy) begin
      chk("hs_input", ia.hs_input, {32'h0000_0280, 320'h0, 32'h8000_0000, m_nonce(), m_tail});
      chk("hs_state", ia.hs_state, m_mid);
    end
  endtask
  task automatic step(input logic rst, input logic jv, input logic [511:0] jd, input logic gh, input logic rdy);
    logic [255:0] h;
    bit gold, load;
    for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
    h[255:224] = gh ? 32'd0 : (h[255:224] | 32'd1);
    rst_n = !rst;
    ia.job_valid = jv;
    ia.job_data = jd;
    ia.hs_hash2 = h;
    ia.result_ready = rdy;
    ib.job_valid = jv_b;
    if (rst) begin
      m_busy = 0; m_rv = 0; m_rn = '0; m_drop = 0; m_gp = 0; t = 0;
    end else begin
      gold = m_busy && gh && t % 32 == 1 && t >= FLUSH_A;
      load = m_gp && !jv;
      m_drop = load && m_rv && !rdy;
      if (load && (!m_rv || rdy)) begin
        m_rn = m_nonce() - OFF_A;
        m_rv = 1;
      end else if (m_rv && rdy) m_rv = 0;
      m_gp = gold && !jv;
      if (jv) begin
        m_busy = 1; t = 0; m_tail = jd[95:0]; m_mid = jd[511:256];
      end else if (m_busy) t++;
    end
    @(negedge hash_clk);
    check_a();
  endtask
  task automatic run_to(input longint tt, input logic rdy);
    for (longint i = t; i < tt; i++) step(0, 0, '0, 0, rdy);
  endtask
  initial begin
    logic [511:0] jd;
    ib.job_data = '1;
    ib.hs_hash2 = '1;
    ib.result_ready = 1'b1;
    step(1, 0, '0, 0, 1);
    step(1, 0, '0, 0, 1);
    chk("b_reset_nonce", ib.cur_nonce, 32'hFFFF_FFF0);
    chk("b_reset_fb", ib.hs_feedback, 1'b1);
    jd = rand_jd();
    jd[95:0] = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    step(0, 1, jd, 0, 1);
    chk("start_input_tail", ia.hs_input[95:0], 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5);
    chk("start_input_hdr", ia.hs_input[511:480], 32'h0000_0280);
    run_to(105 * 32 + 1, 1);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    chk("gold_valid", ia.result_valid, 1'b1);
    chk("gold_nonce", ia.result_nonce, 32'd100);
    run_to(115 * 32 + 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    chk("drop_pulse", ia.result_drop, 1'b1);
    chk("drop_held", ia.result_nonce, 32'd100);
    step(0, 0, '0, 0, 1);
    chk("accept_clear", ia.result_valid, 1'b0);
    chk("drop_once", ia.result_drop, 1'b0);
    run_to(128 * 32 + 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    chk("pend_nonce", ia.result_nonce, 32'd123);
    run_to(128 * 32 + 12, 0);
    step(0, 1, rand_jd(), 0, 0);
    chk("restart_cnt", ia.hs_cnt, 6'd0);
    chk("restart_nonce", ia.cur_nonce, 32'd0);
    chk("restart_keep", ia.result_valid, 1'b1);
    for (int i = 0; i < FLUSH_A; i++) step(0, 0, '0, 1, 1);
    chk("no_stale", ia.result_valid, 1'b0);
    for (int i = 0; i < 5000; i++)
      step(0, $urandom_range(0, 399) == 0, rand_jd(), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++) step(0, 0, '0, 1, 0);
    chk("pre_reset_valid", ia.result_valid, 1'b1);
    step(1, 0, '0, 0, 0);
    chk("reset_valid", ia.result_valid, 1'b0);
    chk("reset_busy", ia.busy, 1'b0);
    chk("reset_cnt", ia.hs_cnt, 6'd0);
    chk("reset_fb", ia.hs_feedback, 1'b1);
    chk("reset_nonce", ia.cur_nonce, 32'd0);
    jv_b = 1'b1;
    step(0, 0, '0, 0, 1);
    jv_b = 1'b0;
    chk("b_start_nonce", ib.cur_nonce, 32'hFFFF_FFF0);
    repeat (63) step(0, 0, '0, 0, 1);
    chk("b_last_nonce", ib.cur_nonce, 32'hFFFF_FFFF);
    chk("b_last_cnt", ib.hs_cnt, 6'd3);
    step(0, 0, '0, 0, 1);
    chk("b_drain_hold", ib.cur_nonce, 32'hFFFF_FFFF);
    chk("b_drain_cnt", ib.hs_cnt, 6'd0);
    chk("b_drain_busy", ib.busy, 1'b1);
    repeat (131) step(0, 0, '0, 0, 1);
    chk("b_drain_end_busy", ib.busy, 1'b1);
    chk("b_drain_end_exh", ib.exhausted, 1'b0);
    step(0, 0, '0, 0, 1);
    chk("b_idle_busy", ib.busy, 1'b0);
    chk("b_exhausted", ib.exhausted, 1'b1);
    chk("b_idle_cnt", ib.hs_cnt, 6'd0);
    chk("b_idle_fb", ib.hs_feedback, 1'b1);
    chk("b_no_result", ib.result_valid, 1'b0);
    jv_b = 1'b1;
    step(0, 0, '0, 0, 1);
    jv_b = 1'b0;
    chk("b_exh_clear", ib.exhausted, 1'b0);
    chk("b_reload_nonce", ib.cur_nonce, 32'hFFFF_FFF0);
    chk("b_reload_busy", ib.busy, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
